// File: rtl/dsp_alu_pkg.sv
// Shared op-code encoding and per-lane flag bit positions for the SIMD DSP ALU.
package dsp_alu_pkg;

    localparam logic [4:0] OpAdd   = 5'b00000;
    localparam logic [4:0] OpSub   = 5'b00001;
    localparam logic [4:0] OpAnd   = 5'b00010;
    localparam logic [4:0] OpOr    = 5'b00011;
    localparam logic [4:0] OpXor   = 5'b00100;
    localparam logic [4:0] OpSll   = 5'b00101;
    localparam logic [4:0] OpSrl   = 5'b00110;
    localparam logic [4:0] OpSra   = 5'b00111;
    localparam logic [4:0] OpSlt   = 5'b01000;
    localparam logic [4:0] OpSltu  = 5'b01001;
    localparam logic [4:0] OpNot   = 5'b01111;
    localparam logic [4:0] OpNeg   = 5'b10000;
    localparam logic [4:0] OpInc   = 5'b10001;
    localparam logic [4:0] OpDec   = 5'b10010;
    localparam logic [4:0] OpEq    = 5'b10011;
    localparam logic [4:0] OpNe    = 5'b10100;
    localparam logic [4:0] OpSat   = 5'b10101;
    localparam logic [4:0] OpClip  = 5'b10110;
    localparam logic [4:0] OpRound = 5'b10111;

    localparam int unsigned NumFlags  = 4;
    localparam int unsigned FlagZero  = 0;
    localparam int unsigned FlagOvf   = 1;
    localparam int unsigned FlagCarry = 2;
    localparam int unsigned FlagNeg   = 3;

endpackage

// File: rtl/dsp_alu_lane.sv
// Combinational single-lane DSP ALU: computes a LANE_W+1 bit raw result, applies optional
// signed saturation and derives the {neg,carry,ovf,zero} flags.
module dsp_alu_lane
    import dsp_alu_pkg::*;
#(
    parameter int unsigned LANE_W = 16
) (
    input  logic [LANE_W-1:0]   a_i,
    input  logic [LANE_W-1:0]   b_i,
    input  logic [4:0]          op_i,
    input  logic                sat_i,
    output logic [LANE_W-1:0]   result_o,
    output logic [NumFlags-1:0] flags_o
);

    localparam int unsigned Msb  = LANE_W - 1;
    localparam int unsigned ShW  = $clog2(LANE_W);
    localparam int unsigned HalfW = LANE_W / 2;

    localparam logic [LANE_W-1:0] MaxPos = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] MinNeg = {1'b1, {(LANE_W-1){1'b0}}};
    // Signed range of a half-width value, sign-extended to the lane.
    localparam logic signed [LANE_W-1:0] SatHi = {{(HalfW+1){1'b0}}, {(HalfW-1){1'b1}}};
    localparam logic signed [LANE_W-1:0] SatLo = {{(HalfW+1){1'b1}}, {(HalfW-1){1'b0}}};

    logic [LANE_W:0]        raw;
    logic [LANE_W-1:0]      res;
    logic                   carry;
    logic                   ovf;
    logic                   valid_op;
    logic [ShW-1:0]         shamt;
    logic signed [LANE_W:0] a_x;
    logic signed [LANE_W:0] b_x;
    logic signed [LANE_W:0] lim;
    logic signed [LANE_W:0] nlim;

    always_comb begin
        raw      = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        valid_op = 1'b1;
        shamt    = b_i[ShW-1:0];
        a_x      = {a_i[Msb], a_i};
        b_x      = {b_i[Msb], b_i};
        lim      = b_x[LANE_W] ? -b_x : b_x;
        nlim     = -lim;

        case (op_i)
            OpAdd: begin
                raw   = {1'b0, a_i} + {1'b0, b_i};
                carry = raw[LANE_W];
                ovf   = (a_i[Msb] == b_i[Msb]) && (raw[Msb] != a_i[Msb]);
            end
            OpSub: begin
                raw   = {1'b0, a_i} - {1'b0, b_i};
                carry = ~raw[LANE_W];
                ovf   = (a_i[Msb] != b_i[Msb]) && (raw[Msb] != a_i[Msb]);
            end
            OpAnd:  raw = {1'b0, a_i & b_i};
            OpOr:   raw = {1'b0, a_i | b_i};
            OpXor:  raw = {1'b0, a_i ^ b_i};
            OpNot:  raw = {1'b0, ~a_i};
            OpSll:  raw = {1'b0, a_i << shamt};
            OpSrl:  raw = {1'b0, a_i >> shamt};
            OpSra:  raw = {1'b0, $signed(a_i) >>> shamt};
            OpSlt:  raw = {{LANE_W{1'b0}}, ($signed(a_i) < $signed(b_i))};
            OpSltu: raw = {{LANE_W{1'b0}}, (a_i < b_i)};
            OpEq:   raw = {{LANE_W{1'b0}}, (a_i == b_i)};
            OpNe:   raw = {{LANE_W{1'b0}}, (a_i != b_i)};
            OpNeg: begin
                raw = '0 - {1'b0, a_i};
                ovf = (a_i == MinNeg);
            end
            OpInc: begin
                raw   = {1'b0, a_i} + {{LANE_W{1'b0}}, 1'b1};
                carry = raw[LANE_W];
                ovf   = ~a_i[Msb] & raw[Msb];
            end
            OpDec: begin
                raw   = {1'b0, a_i} - {{LANE_W{1'b0}}, 1'b1};
                carry = ~raw[LANE_W];
                ovf   = a_i[Msb] & ~raw[Msb];
            end
            OpRound: begin
                raw = {1'b0, a_i} + {{LANE_W{1'b0}}, a_i[0]};
                ovf = ~a_i[Msb] & raw[Msb];
            end
            OpSat: begin
                if ($signed(a_i) > SatHi) begin
                    raw = {1'b0, SatHi};
                end else if ($signed(a_i) < SatLo) begin
                    raw = {1'b0, SatLo};
                end else begin
                    raw = {1'b0, a_i};
                end
            end
            OpClip: begin
                // lim is one bit wider so that |min negative| is representable.
                if (a_x > lim) begin
                    raw = {1'b0, lim[Msb:0]};
                end else if (a_x < nlim) begin
                    raw = {1'b0, nlim[Msb:0]};
                end else begin
                    raw = {1'b0, a_i};
                end
            end
            default: valid_op = 1'b0;
        endcase

        res = raw[Msb:0];
        // On overflow the wrapped sign bit is the inverse of the true sign.
        if (sat_i && ovf) begin
            res = raw[Msb] ? MaxPos : MinNeg;
        end

        result_o = res;
        flags_o  = '0;
        if (valid_op) begin
            flags_o[FlagNeg]   = res[Msb];
            flags_o[FlagCarry] = carry;
            flags_o[FlagOvf]   = ovf;
            flags_o[FlagZero]  = (res == '0);
        end
    end

endmodule

// File: rtl/simd_dsp_alu_pipe.sv
// Two-stage SIMD DSP ALU with valid/ready on both sides. Optional sticky overflow status is
// built when DSP_ALU_STICKY_EN is defined.
module simd_dsp_alu_pipe
    import dsp_alu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned LANE_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_a,
    input  logic [XLEN-1:0]              in_b,
    input  logic [4:0]                   in_op,
    input  logic                         in_sat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_result,
    output logic [4*(XLEN/LANE_W)-1:0]   out_flags
`ifdef DSP_ALU_STICKY_EN
    ,
    input  logic                         clr_sticky,
    output logic                         ovf_sticky
`endif
);

    localparam int unsigned LANES = XLEN / LANE_W;

    if (((LANE_W != 8) && (LANE_W != 16) && (LANE_W != 32)) || ((XLEN % LANE_W) != 0))
    begin : g_bad_cfg
        $error("simd_dsp_alu_pipe: LANE_W must be 8, 16 or 32 and divide XLEN");
    end

    logic                         s1_v_q, s1_v_d;
    logic [XLEN-1:0]              s1_a_q, s1_a_d;
    logic [XLEN-1:0]              s1_b_q, s1_b_d;
    logic [4:0]                   s1_op_q, s1_op_d;
    logic                         s1_sat_q, s1_sat_d;
    logic                         s2_v_q, s2_v_d;
    logic [XLEN-1:0]              res_q, res_d;
    logic [NumFlags*LANES-1:0]    flags_q, flags_d;
    logic                         s1_adv, s2_adv;
    logic [XLEN-1:0]              lane_res;
    logic [NumFlags*LANES-1:0]    lane_flags;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dsp_alu_lane #(
            .LANE_W (LANE_W)
        ) u_lane (
            .a_i      (s1_a_q[i*LANE_W +: LANE_W]),
            .b_i      (s1_b_q[i*LANE_W +: LANE_W]),
            .op_i     (s1_op_q),
            .sat_i    (s1_sat_q),
            .result_o (lane_res[i*LANE_W +: LANE_W]),
            .flags_o  (lane_flags[i*NumFlags +: NumFlags])
        );
    end

    always_comb begin
        s2_adv   = ~s2_v_q | out_ready;
        s1_adv   = ~s1_v_q | s2_adv;

        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_op_d  = s1_op_q;
        s1_sat_d = s1_sat_q;
        s2_v_d   = s2_v_q;
        res_d    = res_q;
        flags_d  = flags_q;

        if (s1_adv) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_op_d  = in_op;
                s1_sat_d = in_sat;
            end
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                res_d   = lane_res;
                flags_d = lane_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= '0;
            s1_sat_q <= 1'b0;
            s2_v_q   <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_op_q  <= s1_op_d;
            s1_sat_q <= s1_sat_d;
            s2_v_q   <= s2_v_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_v_q;
    assign out_result = res_q;
    assign out_flags  = flags_q;

`ifdef DSP_ALU_STICKY_EN
    logic sticky_q, sticky_d;
    logic any_ovf;

    always_comb begin
        any_ovf = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            any_ovf = any_ovf | flags_q[i*NumFlags + FlagOvf];
        end
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (s2_v_q && out_ready && any_ovf) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`endif

endmodule
